fwd_mux_reg: RTL and testbench

Parametrised operand-forwarding selector with a registered output stage, for the pipelined MIPS datapath. It chooses each operand from the register-file read value or from the youngest of N downstream pipeline stages writing the same register. It flags a hazard when the youngest matching producer has no value yet, and latches the chosen operand into a pipeline register with stall, flush and bubble insertion. One instance is used per read operand; it replaces the fixed 4-way operand muxes plus the separate pipeline register.

---
 rtl/fwd_pkg.sv | 21 ++
 rtl/fwd_prio_enc.sv | 26 ++
 rtl/fwd_mux_reg.sv | 96 +++++++++
 tb/tb_fwd_mux_reg.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared forwarding definitions.
//   SEL_RF    : select code meaning "register-file value"
//   sel_code  : maps forwarding source index k to its select code (k+1)
//   opnd_t    : operand bundle carried by the ID/EX stage
package fwd_pkg;

  localparam int SEL_RF = 0;
  localparam int OPND_W = 32;
  localparam int OPND_SW = 2;

  function automatic int sel_code(input int k);
    return k + 1;
  endfunction

  typedef struct packed {
    logic               valid;
    logic [OPND_SW-1:0] sel;
    logic [OPND_W-1:0]  data;
  } opnd_t;

endpackage

// File: rtl/fwd_prio_enc.sv
// Lowest-set-bit priority encoder.
//   match : request vector, bit 0 has the highest priority
//   found : some bit of match is set
//   idx   : index of the lowest set bit (0 when nothing is set)
module fwd_prio_enc #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  match,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (match[k]) begin
        found = 1'b1;
        idx   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_mux_reg.sv
// Operand-forwarding selector with a registered output stage.
// Picks an operand from the register file or from the youngest matching
// downstream producer, flags a hazard when that producer is not ready, and
// captures the result into a stall/flush-capable pipeline register.
//   clk, reset     : clock, asynchronous active-low reset
//   stall, flush   : hold / clear the output stage (flush wins)
//   in_valid       : this cycle's operand request is real
//   rd_addr/rd_data: source register number and register-file value
//   src_*          : per-source address/write-enable/ready/data, k at [k*w +: w]
//   hazard         : combinational, youngest matching producer not ready
//   out_data/out_valid/out_sel : registered operand, valid, select code
//   hazard_cnt     : saturating count of inserted bubbles
module fwd_mux_reg
  import fwd_pkg::*;
#(
  parameter int W  = 32,
  parameter int N  = 3,
  parameter int A  = 5,
  parameter int CW = 16,
  parameter int SW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           flush,
  input  logic           in_valid,
  input  logic [A-1:0]   rd_addr,
  input  logic [W-1:0]   rd_data,
  input  logic [N*A-1:0] src_addr,
  input  logic [N-1:0]   src_wen,
  input  logic [N-1:0]   src_ready,
  input  logic [N*W-1:0] src_data,
  output logic           hazard,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic [SW-1:0]  out_sel,
  output logic [CW-1:0]  hazard_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  match;
  logic          found;
  logic [IW-1:0] idx;
  logic [W-1:0]  sel_data;
  logic [SW-1:0] sel_cd;

  // r0 is hard-wired zero, so writes to it are never forwarded.
  for (genvar k = 0; k < N; k++) begin : g_match
    assign match[k] = src_wen[k] && (src_addr[k*A +: A] == rd_addr) && (rd_addr != '0);
  end

  fwd_prio_enc #(.N(N), .IW(IW)) u_enc (
    .match (match),
    .found (found),
    .idx   (idx)
  );

  // Only the youngest matching producer's ready bit matters; older
  // matches hold stale values and are irrelevant.
  always_comb begin
    sel_data = rd_data;
    sel_cd   = SW'(SEL_RF);
    hazard   = 1'b0;
    if (found) begin
      sel_data = src_data[int'(idx)*W +: W];
      sel_cd   = SW'(sel_code(int'(idx)));
      hazard   = in_valid && !src_ready[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sel    <= '0;
      hazard_cnt <= '0;
    end else if (flush) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
    end else if (!stall) begin
      if (hazard) begin
        // Bubble: data/sel hold, only the valid bit drops.
        out_valid <= 1'b0;
        if (hazard_cnt != {CW{1'b1}})
          hazard_cnt <= hazard_cnt + CW'(1);
      end else begin
        out_valid <= in_valid;
        out_data  <= sel_data;
        out_sel   <= sel_cd;
      end
    end
  end

endmodule

// File: tb/tb_fwd_mux_reg.sv
module tb_fwd_mux_reg;

  localparam int W = 32, N = 3, A = 5, SW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [A-1:0]   rd_addr = '0;
  logic [W-1:0]   rd_data = '0;
  logic [N*A-1:0] src_addr = '0;
  logic [N-1:0]   src_wen = '0, src_ready = '0;
  logic [N*W-1:0] src_data = '0;

  logic           hazard, out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic [15:0]    hazard_cnt;

  logic           hazard_s, out_valid_s;
  logic [W-1:0]   out_data_s;
  logic [SW-1:0]  out_sel_s;
  logic [1:0]     hazard_cnt_s;

  int n_vec = 0, n_err = 0;

  // reference state
  logic [W-1:0] ed;
  logic         ev;
  int           es, ec, ec2;

  always #5 clk = ~clk;

  fwd_mux_reg #(.W(W), .N(N), .A(A), .CW(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .src_addr(src_addr), .src_wen(src_wen),
    .src_ready(src_ready), .src_data(src_data), .hazard(hazard), .out_data(out_data),
    .out_valid(out_valid), .out_sel(out_sel), .hazard_cnt(hazard_cnt)
  );

  fwd_mux_reg #(.W(W), .N(N), .A(A), .CW(2)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .src_addr(src_addr), .src_wen(src_wen),
    .src_ready(src_ready), .src_data(src_data), .hazard(hazard_s), .out_data(out_data_s),
    .out_valid(out_valid_s), .out_sel(out_sel_s), .hazard_cnt(hazard_cnt_s)
  );

  // Youngest writer of rd_addr wins; r0 never forwarded.
  function automatic void model_sel(output bit h, output logic [W-1:0] d, output int code);
    h = 0; d = rd_data; code = 0;
    if (rd_addr != 0)
      for (int k = 0; k < N; k++)
        if (src_wen[k] && src_addr[k*A +: A] == rd_addr) begin
          code = k + 1;
          d    = src_data[k*W +: W];
          h    = in_valid && !src_ready[k];
          break;
        end
  endfunction

  task automatic model_reset();
    ed = '0; ev = 0; es = 0; ec = 0; ec2 = 0;
  endtask

  task automatic tick();
    bit h; logic [W-1:0] d; int c;
    model_sel(h, d, c);
    if (flush) begin
      ev = 0; ed = '0; es = 0;
    end else if (!stall) begin
      if (h) begin
        ev = 0;
        if (ec < 65535) ec++;
        if (ec2 < 3) ec2++;
      end else begin
        ev = in_valid; ed = d; es = c;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; model_reset();
    #3; reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; in_valid = 0; rd_addr = '0; rd_data = '0;
    src_addr = '0; src_wen = '0; src_ready = '0; src_data = '0;
  endtask

  task automatic set_src(input int k, input logic [A-1:0] a, input bit wen,
                         input bit rdy, input logic [W-1:0] d);
    src_addr[k*A +: A] = a; src_wen[k] = wen; src_ready[k] = rdy; src_data[k*W +: W] = d;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    n_vec++;
    if ({out_data, out_valid, out_sel, hazard_cnt} !== '0) begin
      n_err++; $display("FAIL reset_init: got d=%h v=%b s=%0d c=%0d, want all 0",
                        out_data, out_valid, out_sel, hazard_cnt);
    end
    // 7 bubbles, then one valid capture
    in_valid = 1; rd_addr = 5; rd_data = 32'hAAAA; set_src(0, 5, 1, 0, 32'h55);
    repeat (7) tick();
    set_src(0, 5, 1, 1, 32'h55);
    tick();
    n_vec++;
    if (hazard_cnt !== 16'd7 || out_valid !== 1'b1 || out_data !== 32'h55) begin
      n_err++; $display("FAIL reset_pre: got c=%0d v=%b d=%h, want c=7 v=1 d=55",
                        hazard_cnt, out_valid, out_data);
    end
    #2 reset = 1'b0; model_reset();
    #1;
    n_vec++;
    if ({out_data, out_valid, out_sel, hazard_cnt, hazard_cnt_s} !== '0) begin
      n_err++; $display("FAIL reset_async: got d=%h v=%b s=%0d c=%0d, want all 0",
                        out_data, out_valid, out_sel, hazard_cnt);
    end
    reset = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_priority();
    clear_inputs();
    in_valid = 1; rd_addr = 8; rd_data = 32'h99;
    set_src(0, 8, 1, 1, 32'h11);
    set_src(1, 3, 1, 1, 32'h22);
    set_src(2, 8, 1, 1, 32'h33);
    tick();
    n_vec++;
    if (out_data !== 32'h11 || out_sel !== 2'd1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL priority: got d=%h s=%0d v=%b, want d=11 s=1 v=1",
                        out_data, out_sel, out_valid);
    end
  endtask

  task automatic test_r0();
    clear_inputs();
    in_valid = 1; rd_addr = 0; rd_data = 32'h1234;
    set_src(0, 0, 1, 0, 32'hFF);
    #1;
    n_vec++;
    if (hazard !== 1'b0) begin
      n_err++; $display("FAIL r0_hazard: got %b want 0", hazard);
    end
    tick();
    n_vec++;
    if (out_data !== 32'h1234 || out_sel !== 2'd0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL r0_data: got d=%h s=%0d v=%b, want d=1234 s=0 v=1",
                        out_data, out_sel, out_valid);
    end
  endtask

  task automatic test_hazard();
    logic [W-1:0] prev_d; int prev_c;
    clear_inputs();
    in_valid = 1; rd_addr = 4; rd_data = 32'h7;
    set_src(0, 4, 1, 0, 32'h40);
    set_src(1, 4, 1, 1, 32'h41);
    prev_d = ed; prev_c = ec;
    #1;
    n_vec++;
    if (hazard !== 1'b1) begin
      n_err++; $display("FAIL hazard_flag: got %b want 1", hazard);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== prev_d || hazard_cnt !== 16'(prev_c + 1)) begin
      n_err++; $display("FAIL hazard_bubble: got v=%b d=%h c=%0d, want v=0 d=%h c=%0d",
                        out_valid, out_data, hazard_cnt, prev_d, prev_c + 1);
    end
  endtask

  task automatic test_flush_stall();
    int prev_c;
    clear_inputs();
    in_valid = 1; rd_addr = 6; rd_data = 32'h66;
    set_src(0, 6, 1, 1, 32'hCAFE);
    tick();                       // load something nonzero
    set_src(0, 6, 1, 0, 32'hCAFE);
    flush = 1; stall = 1;
    prev_c = ec;
    #1;
    n_vec++;
    if (hazard !== 1'b1) begin
      n_err++; $display("FAIL flush_hazard_ungated: got %b want 1", hazard);
    end
    tick();
    n_vec++;
    if (out_data !== '0 || out_valid !== 1'b0 || out_sel !== '0 || hazard_cnt !== 16'(prev_c)) begin
      n_err++; $display("FAIL flush: got d=%h v=%b s=%0d c=%0d, want d=0 v=0 s=0 c=%0d",
                        out_data, out_valid, out_sel, hazard_cnt, prev_c);
    end
    flush = 0;
    set_src(0, 6, 1, 1, 32'hBEEF);
    tick();
    n_vec++;
    if (out_data !== '0 || out_valid !== 1'b0 || out_sel !== '0 || hazard_cnt !== 16'(prev_c)) begin
      n_err++; $display("FAIL stall_hold: got d=%h v=%b s=%0d c=%0d, want held 0/0/0/%0d",
                        out_data, out_valid, out_sel, hazard_cnt, prev_c);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clear_inputs();
    do_reset();
    in_valid = 1; rd_addr = 9;
    set_src(2, 9, 1, 0, 32'h9);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (hazard_cnt_s !== want[i] || hazard_cnt !== 16'(ec)) begin
        n_err++; $display("FAIL saturate[%0d]: got cs=%0d c=%0d, want cs=%0d c=%0d",
                          i, hazard_cnt_s, hazard_cnt, want[i], ec);
      end
    end
  endtask

  task automatic test_random();
    bit h; logic [W-1:0] d; int c;
    for (int i = 0; i < 300; i++) begin
      stall    = ($urandom_range(5) == 0);
      flush    = ($urandom_range(7) == 0);
      in_valid = $urandom_range(1);
      rd_addr  = A'($urandom_range(3));
      rd_data  = $urandom;
      for (int k = 0; k < N; k++)
        set_src(k, A'($urandom_range(3)), $urandom_range(1), $urandom_range(1), $urandom);
      #1;
      model_sel(h, d, c);
      n_vec++;
      if (hazard !== h) begin
        n_err++; $display("FAIL rnd_hazard[%0d]: got %b want %b", i, hazard, h);
      end
      tick();
      n_vec++;
      if (out_data !== ed || out_valid !== ev || out_sel !== SW'(es) ||
          hazard_cnt !== 16'(ec) || hazard_cnt_s !== 2'(ec2) || out_data_s !== ed) begin
        n_err++; $display("FAIL rnd_out[%0d]: got d=%h v=%b s=%0d c=%0d cs=%0d, want d=%h v=%b s=%0d c=%0d cs=%0d",
                          i, out_data, out_valid, out_sel, hazard_cnt, hazard_cnt_s,
                          ed, ev, es, ec, ec2);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_r0();
    test_hazard();
    test_flush_stall();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
